frame_check: RTL and testbench
==============================

FRAME_CHECK -- requirements
Module: frame_check

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, maximum data bits per frame (legal 5..9).
REQ-002 SHALL have parameter CNT_WIDTH, default 8, width of each saturating error counter.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port bit_vld  input  1  one-cycle strobe; sampled_bit is valid this cycle.
REQ-006 SHALL have port sampled_bit  input  1  serial line sample.
REQ-007 SHALL have port DATA_LEN  input  4  data bits per frame, 5..DATA_WIDTH.
REQ-008 SHALL have port PAR_EN  input  1  parity bit present.
REQ-009 SHALL have port PAR_TYP  input  2  00 even, 01 odd, 10 mark (parity bit must be 1), 11 space (must be 0).
REQ-010 SHALL have port STP_2  input  1  two stop bits expected.
REQ-011 SHALL have port clr_cnt  input  1  synchronous clear of both error counters.
REQ-012 SHALL have port P_DATA  output  DATA_WIDTH  last received data, LSB-aligned, upper bits zero.
REQ-013 SHALL have port data_valid  output  1  one-cycle pulse: error-free frame delivered.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse at end of every frame.
REQ-015 SHALL have port par_err  output  1  parity error of last frame, valid with frame_done.
REQ-016 SHALL have port stp_err  output  1  stop error of last frame, valid with frame_done.
REQ-017 SHALL have port par_err_cnt / stp_err_cnt  output  CNT_WIDTH each  saturating error counts.

Function
REQ-018 SHALL implement FSM states IDLE, DATA, PARITY, STOP; state advances only on cycles with bit_vld=1.
REQ-019 IDLE: bit_vld with sampled_bit=0 SHALL be accepted as start bit -> DATA; sampled_bit=1 SHALL be ignored.
REQ-020 On start acceptance DATA_LEN, PAR_EN, PAR_TYP, STP_2 SHALL be latched; changes mid-frame SHALL have no effect until next frame.
REQ-021 Latched DATA_LEN outside 5..DATA_WIDTH SHALL be treated as DATA_WIDTH.
REQ-022 DATA: bits SHALL be shifted LSB-first; after DATA_LEN bits -> PARITY if PAR_EN else STOP.
REQ-023 PARITY: expected bit SHALL be XOR of received data (even), its inverse (odd), 1 (mark) or 0 (space); mismatch sets internal parity flag; -> STOP.
REQ-024 STOP: each stop bit SHALL be 1, any 0 sets internal stop flag; after 1 (STP_2=0) or 2 (STP_2=1) stop bits -> IDLE.
REQ-025 With STP_2=1 and first stop bit 0, the second stop bit SHALL still be consumed before returning to IDLE.
REQ-026 One cycle after bit_vld of the final stop bit: frame_done=1, par_err and stp_err show the frame flags, all for exactly one cycle.
REQ-027 In that same cycle data_valid SHALL be 1 and P_DATA updated only if both flags are 0; otherwise P_DATA SHALL hold its previous value.
REQ-028 par_err SHALL be 0 for frames with PAR_EN=0.
REQ-029 par_err_cnt / stp_err_cnt SHALL increment by 1 in the frame_done cycle of a frame with the matching flag set; both may increment in the same cycle.
REQ-030 Counters SHALL saturate at 2^CNT_WIDTH-1 and not wrap.
REQ-031 clr_cnt in the same cycle as an increment SHALL win; counter becomes 0.
REQ-032 A bit_vld arriving in the frame_done cycle while in IDLE SHALL be processed as a possible start bit (back-to-back frames, no lost bit).
REQ-033 Latency from final stop bit strobe to data_valid SHALL be exactly 1 cycle.

Reset
REQ-034 rst=1 SHALL force state IDLE, P_DATA=0, data_valid=0, frame_done=0, par_err=0, stp_err=0, both counters=0, internal flags and bit counter cleared.
REQ-035 rst asserted mid-frame SHALL abort the frame with no frame_done pulse and no counter update.
REQ-036 rst SHALL take priority over clr_cnt and all other inputs.

Verification
REQ-037 8N1, data 0xA5, stop 1 -> data_valid=1, P_DATA=0xA5, par_err=0, stp_err=0, counters unchanged.
REQ-038 8E1, data 0x03, parity bit 1 (expected 0) -> frame_done=1, par_err=1, data_valid=0, par_err_cnt 0->1, P_DATA unchanged.
REQ-039 7O2, data 0x41, parity 1, stop bits 1,0 -> stp_err=1, par_err=0, stp_err_cnt +1; DATA_LEN changed to 5 mid-frame has no effect.
REQ-040 Mark-parity frame with parity bit 0 while stop bit also 0 -> par_err=1, stp_err=1, both counters +1 same cycle.
REQ-041 CNT_WIDTH=2, four parity-error frames -> par_err_cnt=3; clr_cnt coincident with fifth error -> 0.
REQ-042 rst pulse after 4 data bits, then clean 8N1 frame 0x5A -> no pulse for aborted frame; data_valid=1, P_DATA=0x5A.

Source files
------------

// File: rtl/frame_check.sv
// Receive-side UART frame checker: deserialises strobed bits, checks parity and stop bits,
// and keeps saturating per-error-type counters.
module frame_check #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bit_vld,
    input  logic                  sampled_bit,
    input  logic [3:0]            DATA_LEN,
    input  logic                  PAR_EN,
    input  logic [1:0]            PAR_TYP,
    input  logic                  STP_2,
    input  logic                  clr_cnt,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  frame_done,
    output logic                  par_err,
    output logic                  stp_err,
    output logic [CNT_WIDTH-1:0]  par_err_cnt,
    output logic [CNT_WIDTH-1:0]  stp_err_cnt
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DATA   = 2'd1;
    localparam logic [1:0] PARITY = 2'd2;
    localparam logic [1:0] STOP   = 2'd3;

    localparam logic [3:0]           MAX_LEN = 4'(DATA_WIDTH);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [1:0]            state;
    logic [3:0]            len_q;
    logic [3:0]            bit_cnt;
    logic                  par_en_q;
    logic [1:0]            par_typ_q;
    logic                  stp2_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  par_flag;
    logic                  stp_flag;
    logic                  stop_cnt;

    logic exp_par;
    logic last_stop;
    logic frame_stp;
    logic frame_good;

    // Upper shift bits are cleared at start, so XOR over the whole register equals XOR of the frame data.
    always_comb begin
        exp_par = 1'b0;
        case (par_typ_q)
            2'b00:   exp_par = ^shift_q;
            2'b01:   exp_par = ~^shift_q;
            2'b10:   exp_par = 1'b1;
            default: exp_par = 1'b0;
        endcase
    end

    assign last_stop  = (state == STOP) && bit_vld && (!stp2_q || stop_cnt);
    assign frame_stp  = stp_flag | ~sampled_bit;
    assign frame_good = !par_flag && !frame_stp;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            len_q     <= MAX_LEN;
            bit_cnt   <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 2'b00;
            stp2_q    <= 1'b0;
            shift_q   <= '0;
            par_flag  <= 1'b0;
            stp_flag  <= 1'b0;
            stop_cnt  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bit_vld && !sampled_bit) begin
                        state     <= DATA;
                        len_q     <= (DATA_LEN < 4'd5 || DATA_LEN > MAX_LEN) ? MAX_LEN : DATA_LEN;
                        par_en_q  <= PAR_EN;
                        par_typ_q <= PAR_TYP;
                        stp2_q    <= STP_2;
                        bit_cnt   <= '0;
                        shift_q   <= '0;
                        par_flag  <= 1'b0;
                        stp_flag  <= 1'b0;
                        stop_cnt  <= 1'b0;
                    end
                end
                DATA: begin
                    if (bit_vld) begin
                        for (int i = 0; i < DATA_WIDTH; i++) begin
                            if (bit_cnt == 4'(i)) shift_q[i] <= sampled_bit;
                        end
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == len_q - 4'd1) state <= par_en_q ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    if (bit_vld) begin
                        par_flag <= (sampled_bit != exp_par);
                        state    <= STOP;
                    end
                end
                STOP: begin
                    // A bad first stop bit still consumes the second one in two-stop mode.
                    if (bit_vld) begin
                        stp_flag <= frame_stp;
                        stop_cnt <= 1'b1;
                        if (!stp2_q || stop_cnt) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            P_DATA     <= '0;
            data_valid <= 1'b0;
            frame_done <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
        end else begin
            frame_done <= last_stop;
            par_err    <= last_stop && par_flag;
            stp_err    <= last_stop && frame_stp;
            data_valid <= last_stop && frame_good;
            if (last_stop && frame_good) P_DATA <= shift_q;
        end
    end

    // Clear beats a coincident increment; both counters stick at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_err_cnt <= '0;
            stp_err_cnt <= '0;
        end else if (clr_cnt) begin
            par_err_cnt <= '0;
            stp_err_cnt <= '0;
        end else begin
            if (last_stop && par_flag && par_err_cnt != CNT_MAX)
                par_err_cnt <= par_err_cnt + CNT_ONE;
            if (last_stop && frame_stp && stp_err_cnt != CNT_MAX)
                stp_err_cnt <= stp_err_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_frame_check.sv
// Self-checking bench for frame_check: frames are driven bit by bit and their expected
// outcome is queued, then popped and compared when frame_done is due.
module tb_frame_check;

    localparam int DW = 8;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          bit_vld;
    logic          sampled_bit;
    logic [3:0]    DATA_LEN;
    logic          PAR_EN;
    logic [1:0]    PAR_TYP;
    logic          STP_2;
    logic          clr_cnt;
    logic [DW-1:0] P_DATA;
    logic          data_valid;
    logic          frame_done;
    logic          par_err;
    logic          stp_err;
    logic [CW-1:0] par_err_cnt;
    logic [CW-1:0] stp_err_cnt;

    frame_check #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .bit_vld     (bit_vld),
        .sampled_bit (sampled_bit),
        .DATA_LEN    (DATA_LEN),
        .PAR_EN      (PAR_EN),
        .PAR_TYP     (PAR_TYP),
        .STP_2       (STP_2),
        .clr_cnt     (clr_cnt),
        .P_DATA      (P_DATA),
        .data_valid  (data_valid),
        .frame_done  (frame_done),
        .par_err     (par_err),
        .stp_err     (stp_err),
        .par_err_cnt (par_err_cnt),
        .stp_err_cnt (stp_err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          perr;
        logic          serr;
        logic          dv;
        logic [DW-1:0] pdata;
        logic [CW-1:0] pcnt;
        logic [CW-1:0] scnt;
    } exp_t;

    exp_t          sb[$];
    int            checks = 0;
    int            errors = 0;
    int            done_req = 0;
    int            done_seen = 0;
    logic [DW-1:0] pdata_m = '0;
    int            pcnt_m = 0;
    int            scnt_m = 0;
    int            cnt_max = (1 << CW) - 1;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Frame results are only legal on the cycle right after a final stop-bit strobe.
    always @(negedge clk) begin
        if (!rst) begin
            if (done_req != done_seen) begin
                done_seen++;
                checkOutput("frame_done", {31'd0, frame_done}, 32'd1);
                if (sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("par_err", {31'd0, par_err}, {31'd0, e.perr});
                    checkOutput("stp_err", {31'd0, stp_err}, {31'd0, e.serr});
                    checkOutput("data_valid", {31'd0, data_valid}, {31'd0, e.dv});
                    checkOutput("P_DATA", 32'(P_DATA), 32'(e.pdata));
                    checkOutput("par_err_cnt", 32'(par_err_cnt), 32'(e.pcnt));
                    checkOutput("stp_err_cnt", 32'(stp_err_cnt), 32'(e.scnt));
                end else begin
                    checkOutput("sb_depth", sb.size(), 32'd1);
                end
            end else begin
                checkOutput("frame_done_idle", {31'd0, frame_done}, 32'd0);
                checkOutput("data_valid_idle", {31'd0, data_valid}, 32'd0);
            end
        end
    end

    task automatic sendBit(input logic b, input int gap);
        bit_vld     = 1'b1;
        sampled_bit = b;
        @(posedge clk);
        #1;
        bit_vld     = 1'b0;
        sampled_bit = 1'($urandom_range(0, 1));
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [DW-1:0] data, input logic [3:0] len, input logic pen,
                                 input logic [1:0] ptyp, input logic stp2, input logic pbit,
                                 input logic s1, input logic s2, input int after_gap, input logic clr_last);
        int            n;
        logic [DW-1:0] d;
        logic          ep;
        logic          perr;
        logic          serr;
        logic          last;
        exp_t          e;
        n = (len < 5 || int'(len) > DW) ? DW : int'(len);
        d = '0;
        for (int i = 0; i < n; i++) d[i] = data[i];
        case (ptyp)
            2'b00:   ep = ^d;
            2'b01:   ep = ~(^d);
            2'b10:   ep = 1'b1;
            default: ep = 1'b0;
        endcase
        perr = pen && (pbit != ep);
        serr = !s1 || (stp2 && !s2);
        if (!perr && !serr) pdata_m = d;
        if (clr_last) begin
            pcnt_m = 0;
            scnt_m = 0;
        end else begin
            if (perr && pcnt_m < cnt_max) pcnt_m++;
            if (serr && scnt_m < cnt_max) scnt_m++;
        end
        e.perr  = perr;
        e.serr  = serr;
        e.dv    = !perr && !serr;
        e.pdata = pdata_m;
        e.pcnt  = pcnt_m[CW-1:0];
        e.scnt  = scnt_m[CW-1:0];
        sb.push_back(e);

        DATA_LEN = len;
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
        STP_2    = stp2;
        sendBit(1'b0, $urandom_range(0, 2));
        // Mid-frame configuration changes must not affect the frame in flight.
        DATA_LEN = 4'd5;
        PAR_EN   = ~pen;
        PAR_TYP  = ~ptyp;
        STP_2    = ~stp2;
        for (int i = 0; i < n; i++) sendBit(d[i], $urandom_range(0, 2));
        if (pen) sendBit(pbit, $urandom_range(0, 2));
        if (stp2) sendBit(s1, $urandom_range(0, 2));
        last        = stp2 ? s2 : s1;
        clr_cnt     = clr_last;
        bit_vld     = 1'b1;
        sampled_bit = last;
        @(posedge clk);
        #1;
        done_req++;
        bit_vld     = 1'b0;
        clr_cnt     = 1'b0;
        sampled_bit = 1'b1;
        repeat (after_gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulseClear();
        clr_cnt = 1'b1;
        @(posedge clk);
        #1;
        clr_cnt = 1'b0;
        pcnt_m  = 0;
        scnt_m  = 0;
        checkOutput("clr_par_cnt", 32'(par_err_cnt), 32'd0);
        checkOutput("clr_stp_cnt", 32'(stp_err_cnt), 32'd0);
    endtask

    initial begin
        rst         = 1'b1;
        bit_vld     = 1'b0;
        sampled_bit = 1'b1;
        DATA_LEN    = 4'd8;
        PAR_EN      = 1'b0;
        PAR_TYP     = 2'b00;
        STP_2       = 1'b0;
        clr_cnt     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_P_DATA", 32'(P_DATA), 32'd0);
        checkOutput("rst_frame_done", {31'd0, frame_done}, 32'd0);
        checkOutput("rst_data_valid", {31'd0, data_valid}, 32'd0);
        checkOutput("rst_par_cnt", 32'(par_err_cnt), 32'd0);
        checkOutput("rst_stp_cnt", 32'(stp_err_cnt), 32'd0);
        rst = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end

        applyStimulus(8'hA5, 4'd8, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 2, 1'b0);
        applyStimulus(8'h03, 4'd8, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 2, 1'b0);
        applyStimulus(8'h41, 4'd7, 1'b1, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0, 2, 1'b0);
        applyStimulus(8'h5C, 4'd8, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b0);
        applyStimulus(8'h37, 4'd8, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        applyStimulus(8'h15, 4'd5, 1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 0, 1'b0);
        applyStimulus(8'h3C, 4'd8, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 3, 1'b0);
        applyStimulus(8'hC3, 4'd3, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 2, 1'b0);
        applyStimulus(8'h81, 4'd15, 1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 2, 1'b0);

        pulseClear();
        for (int k = 0; k < 4; k++)
            applyStimulus(8'h01, 4'd8, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b0);
        applyStimulus(8'h01, 4'd8, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 2, 1'b1);
        applyStimulus(8'h2B, 4'd8, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b0);

        // Abort a frame part-way through the data bits.
        DATA_LEN = 4'd8;
        PAR_EN   = 1'b0;
        STP_2    = 1'b0;
        sendBit(1'b0, 1);
        for (int i = 0; i < 4; i++) sendBit(1'(i & 1), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort_P_DATA", 32'(P_DATA), 32'd0);
        checkOutput("abort_stp_cnt", 32'(stp_err_cnt), 32'd0);
        checkOutput("abort_frame_done", {31'd0, frame_done}, 32'd0);
        rst     = 1'b0;
        pdata_m = '0;
        pcnt_m  = 0;
        scnt_m  = 0;
        applyStimulus(8'h5A, 4'd8, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 4, 1'b0);

        checkOutput("sb_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
